// File: rtl/mux_pkg.sv
// Shared state type and width/placement helpers for the crossfading channel mux.
package mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  // Upper bound for the crossfade length exponent.
  localparam int RAMP_LOG2_MAX = 12;

  function automatic int prod_width(input int width, input int ramp_log2);
    return width + ramp_log2 + 1;
  endfunction

  function automatic int sum_width(input int width, input int ramp_log2);
    return width + ramp_log2 + 2;
  endfunction

  // LSB position of channel c inside the packed input bus.
  function automatic int chan_lsb(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/xfade_lerp.sv
// Combinational weighted mix y = floor((a*(2^R - k) + b*k) / 2^R), R = RAMP_LOG2.
module xfade_lerp
  import mux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAMP_LOG2 = 8
) (
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic        [RAMP_LOG2-1:0] k,
  output logic signed [WIDTH-1:0]     y
);

  localparam int PROD_W = prod_width(WIDTH, RAMP_LOG2);
  localparam int SUM_W  = sum_width(WIDTH, RAMP_LOG2);

  logic        [RAMP_LOG2:0] wa_s;
  logic        [RAMP_LOG2:0] wb_s;
  logic signed [PROD_W-1:0]  prod_a_s;
  logic signed [PROD_W-1:0]  prod_b_s;
  logic signed [SUM_W-1:0]   sum_s;

  // Weights are zero-extended so they stay non-negative in the signed products.
  always_comb begin
    wb_s     = {1'b0, k};
    wa_s     = {1'b1, {RAMP_LOG2{1'b0}}} - wb_s;
    prod_a_s = PROD_W'(a) * $signed(PROD_W'(wa_s));
    prod_b_s = PROD_W'(b) * $signed(PROD_W'(wb_s));
    sum_s    = SUM_W'(prod_a_s) + SUM_W'(prod_b_s);
    y        = WIDTH'(sum_s >>> RAMP_LOG2);
  end

endmodule

// File: rtl/mux_nx1_xfade.sv
// N:1 registered sample mux. With MUX_XFADE_EN defined a select change crossfades
// over 2^RAMP_LOG2 cycles; otherwise the select switches hard with 1-cycle latency.
module mux_nx1_xfade
  import mux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int N_IN      = 4,
  parameter int SEL_W     = $clog2(N_IN),
  parameter int RAMP_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_IN*WIDTH-1:0] in_i,
  output logic [WIDTH-1:0]      out_o,
  output logic                  busy_o,
  output logic [SEL_W-1:0]      active_sel_o
);

  localparam int              N_PAD    = 1 << SEL_W;
  localparam logic [SEL_W:0]  N_IN_VAL = (SEL_W + 1)'(N_IN);

  logic [WIDTH-1:0] chan_s [N_PAD];
  logic             sel_ok_s;
  logic [SEL_W-1:0] cur_r;
  logic [WIDTH-1:0] out_r;

  // Unused select codes above N_IN read as zero so every index is defined.
  for (genvar c = 0; c < N_PAD; c++) begin : g_chan
    if (c < N_IN) begin : g_live
      assign chan_s[c] = in_i[chan_lsb(c, WIDTH) +: WIDTH];
    end else begin : g_pad
      assign chan_s[c] = {WIDTH{1'b0}};
    end
  end

  assign sel_ok_s = ({1'b0, sel_i} < N_IN_VAL);

`ifdef MUX_XFADE_EN

  state_e               state_r;
  state_e               state_n;
  logic [SEL_W-1:0]     cur_n;
  logic [SEL_W-1:0]     nxt_r;
  logic [SEL_W-1:0]     nxt_n;
  logic [RAMP_LOG2-1:0] k_r;
  logic [RAMP_LOG2-1:0] k_n;
  logic [WIDTH-1:0]     out_n;
  logic [WIDTH-1:0]     lerp_s;
  logic                 busy_r;

  xfade_lerp #(
    .WIDTH    (WIDTH),
    .RAMP_LOG2(RAMP_LOG2)
  ) u_lerp (
    .a(chan_s[cur_r]),
    .b(chan_s[nxt_r]),
    .k(k_r),
    .y(lerp_s)
  );

  // Next-state logic: select changes are only accepted from IDLE.
  always_comb begin
    state_n = state_r;
    cur_n   = cur_r;
    nxt_n   = nxt_r;
    k_n     = k_r;
    out_n   = out_r;
    case (state_r)
      IDLE: begin
        out_n = chan_s[cur_r];
        if (sel_ok_s && (sel_i != cur_r)) begin
          nxt_n   = sel_i;
          k_n     = RAMP_LOG2'(1'b1);
          state_n = FADE;
        end else begin
          nxt_n = nxt_r;
        end
      end
      FADE: begin
        out_n = lerp_s;
        if (&k_r) begin
          cur_n   = nxt_r;
          k_n     = {RAMP_LOG2{1'b0}};
          state_n = IDLE;
        end else begin
          k_n = k_r + RAMP_LOG2'(1'b1);
        end
      end
      default: begin
        state_n = IDLE;
        k_n     = {RAMP_LOG2{1'b0}};
      end
    endcase
  end

  // State and output registers; reset aborts any fade in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cur_r   <= {SEL_W{1'b0}};
      nxt_r   <= {SEL_W{1'b0}};
      k_r     <= {RAMP_LOG2{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cur_r   <= cur_n;
      nxt_r   <= nxt_n;
      k_r     <= k_n;
      out_r   <= out_n;
      busy_r  <= (state_n == FADE);
    end
  end

  assign busy_o = busy_r;

`else

  // Hard switch: out-of-range selects keep the committed channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_r <= {SEL_W{1'b0}};
      out_r <= {WIDTH{1'b0}};
    end else if (sel_ok_s) begin
      cur_r <= sel_i;
      out_r <= chan_s[sel_i];
    end else begin
      cur_r <= cur_r;
      out_r <= chan_s[cur_r];
    end
  end

  assign busy_o = 1'b0;

`endif

  assign out_o        = out_r;
  assign active_sel_o = cur_r;

endmodule

// File: tb/tb_mux_nx1_xfade.sv
// Randomized bench for mux_nx1_xfade against a time-based reference model.
module tb_mux_nx1_xfade;

  typedef struct {
    int     cur;
    int     to;
    int     start;
    bit     fading;
    longint out;
    bit     busy;
  } mdl_t;

  logic        clk;
  logic        rst;
  logic [1:0]  sel_a;
  logic [63:0] bus_a;
  logic [15:0] out_a;
  logic        busy_a;
  logic [1:0]  act_a;
  logic [2:0]  sel_b;
  logic [79:0] bus_b;
  logic [15:0] out_b;
  logic        busy_b;
  logic [2:0]  act_b;
  logic signed [15:0] la, lb, ly;
  logic [1:0]  lk;

  int     ch_a [8];
  int     ch_b [8];
  int     n_checks;
  int     n_errors;
  int     cyc;
  mdl_t   ma, mb;
  longint prev;

  mux_nx1_xfade #(.WIDTH(16), .N_IN(4), .RAMP_LOG2(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .sel_i(sel_a), .in_i(bus_a),
    .out_o(out_a), .busy_o(busy_a), .active_sel_o(act_a));

  mux_nx1_xfade #(.WIDTH(16), .N_IN(5), .RAMP_LOG2(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .sel_i(sel_b), .in_i(bus_b),
    .out_o(out_b), .busy_o(busy_b), .active_sel_o(act_b));

  xfade_lerp #(.WIDTH(16), .RAMP_LOG2(2)) u_lerp (.a(la), .b(lb), .k(lk), .y(ly));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus_a = 64'd0;
    bus_b = 80'd0;
    for (int c = 0; c < 4; c++) bus_a[c*16 +: 16] = 16'(ch_a[c]);
    for (int c = 0; c < 5; c++) bus_b[c*16 +: 16] = 16'(ch_b[c]);
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  // Output of one edge: a fade started at cycle s blends linearly with weight (t-s)/2^r.
  function automatic mdl_t mdl_edge(input mdl_t m, input bit rst_v, input int sel_v,
                                    input int v[8], input int n, input int r, input int cyc_v);
    mdl_t   o;
    longint span;
    longint j;
    o    = m;
    span = longint'(1) << r;
    if (rst_v) begin
      o.cur = 0; o.to = 0; o.start = 0; o.fading = 1'b0; o.out = 0;
    end
`ifdef MUX_XFADE_EN
    else if (o.fading) begin
      j = longint'(cyc_v - o.start);
      o.out = fdiv(longint'(v[o.cur]) * (span - j) + longint'(v[o.to]) * j, span);
      if (j == span - 1) begin
        o.cur    = o.to;
        o.fading = 1'b0;
      end
    end else begin
      o.out = longint'(v[o.cur]);
      if (sel_v != o.cur && sel_v < n) begin
        o.to     = sel_v;
        o.fading = 1'b1;
        o.start  = cyc_v;
      end
    end
`else
    else if (sel_v < n) begin
      o.out = longint'(v[sel_v]);
      o.cur = sel_v;
    end else begin
      o.out = longint'(v[o.cur]);
    end
`endif
    o.busy = o.fading;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    ma = mdl_edge(ma, rst, int'(sel_a), ch_a, 4, 2, cyc);
    mb = mdl_edge(mb, rst, int'(sel_b), ch_b, 5, 4, cyc);
    @(negedge clk);
    check_eq("a_out",  longint'($signed(out_a)), ma.out);
    check_eq("a_busy", longint'(busy_a), longint'(ma.busy));
    check_eq("a_sel",  longint'(act_a), longint'(ma.cur));
    check_eq("b_out",  longint'($signed(out_b)), mb.out);
    check_eq("b_busy", longint'(busy_b), longint'(mb.busy));
    check_eq("b_sel",  longint'(act_b), longint'(mb.cur));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic lerp_check(input int a, input int b, input int k);
    la = 16'(a);
    lb = 16'(b);
    lk = 2'(k);
    #1;
    check_eq("lerp", longint'(ly), fdiv(longint'(a) * (4 - k) + longint'(b) * k, 4));
  endtask

`ifdef MUX_XFADE_EN
  int exp_fade [5] = '{1000, 500, 0, -500, -1000};
  int exp_mid  [2] = '{400, -400};
`else
  int exp_fade [5] = '{-1000, -1000, -1000, -1000, -1000};
  int exp_mid  [2] = '{-400, -400};
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    ma       = '{cur: 0, to: 0, start: 0, fading: 1'b0, out: 0, busy: 1'b0};
    mb       = ma;
    for (int c = 0; c < 8; c++) begin
      ch_a[c] = 0;
      ch_b[c] = 0;
    end
    ch_b[0] = 100; ch_b[1] = -200; ch_b[2] = 300; ch_b[3] = -400; ch_b[4] = 500;
    ch_a[0] = 1234;
    sel_a = 2'd0;
    sel_b = 3'd0;
    rst   = 1'b1;

    // Mixer unit: corners then random weights.
    lerp_check(-32768, 32767, 3);
    lerp_check(32767, -32768, 1);
    lerp_check(-7, 5, 0);
    lerp_check(-1, 0, 1);
    for (int i = 0; i < 40; i++)
      lerp_check(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 3)));

    // Reset holds zero, then channel 0 appears one edge after release.
    steps(3);
    check_eq("rst_out", longint'($signed(out_a)), 0);
    rst = 1'b0;
    step();
    check_eq("rel_out", longint'($signed(out_a)), 1234);
    check_eq("rel_busy", longint'(busy_a), 0);

    // Basic 0 -> 1 fade.
    ch_a[0] = 1000; ch_a[1] = -1000;
    sel_a = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("fade01", longint'($signed(out_a)), longint'(exp_fade[i]));
    end
    check_eq("fade01_sel", longint'(act_a), 1);
    sel_a = 2'd0;
    steps(6);

    // Select change during a fade is deferred until the fade completes.
    ch_a[2] = 400; ch_a[3] = -400;
    sel_a = 2'd2;
    step();
    sel_a = 2'd3;
    steps(4);
    check_eq("mid_e4", longint'($signed(out_a)), longint'(exp_mid[0]));
    steps(4);
    check_eq("mid_e8", longint'($signed(out_a)), longint'(exp_mid[1]));

    // Out-of-range selects on the five-channel instance are ignored.
    sel_b = 3'd4;
    steps(20);
    check_eq("oor_pre", longint'(act_b), 4);
    for (int s = 5; s < 8; s++) begin
      sel_b = 3'(s);
      steps(3);
      check_eq("oor_sel", longint'(act_b), 4);
      check_eq("oor_out", longint'($signed(out_b)), 500);
      check_eq("oor_busy", longint'(busy_b), 0);
    end

    // Full-scale fade must rise monotonically.
    ch_b[0] = -32768; ch_b[1] = 32767;
    sel_b = 3'd0;
    steps(20);
    prev = longint'($signed(out_b));
    sel_b = 3'd1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("mono", longint'($signed(out_b) >= prev), 1);
      prev = longint'($signed(out_b));
    end

    // Reset in the middle of a fade.
    sel_a = 2'd0;
    steps(6);
    sel_a = 2'd1;
    steps(2);
    rst = 1'b1;
    step();
    check_eq("abort_out", longint'($signed(out_a)), 0);
    check_eq("abort_sel", longint'(act_a), 0);
    rst   = 1'b0;
    sel_a = 2'd3;
    steps(6);

    // Random traffic with live inputs and occasional resets.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 5; c++) begin
        ch_a[c] = int'($urandom_range(0, 65535)) - 32768;
        ch_b[c] = int'($urandom_range(0, 65535)) - 32768;
      end
      if ($urandom_range(0, 3) == 0) sel_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sel_b = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
